// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with valid/ready handshakes and a two-entry skid buffer.
// Define DECODE_RV32M_EN to also decode the RV32M multiply/divide group.
module decode_stage #(
  parameter int WIDTH = 32,
  parameter int PC_WIDTH = 32,
  parameter int REG_WIDTH = 5,
  parameter int INSTR_TYPE_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            inst,
  input  logic [PC_WIDTH-1:0]         in_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PC_WIDTH-1:0]         out_pc,
  output logic [INSTR_TYPE_WIDTH-1:0] instr_type,
  output logic [REG_WIDTH-1:0]        rd,
  output logic [REG_WIDTH-1:0]        rs1,
  output logic [REG_WIDTH-1:0]        rs2,
  output logic                        rde,
  output logic                        rs1e,
  output logic                        rs2e,
  output logic [WIDTH-1:0]            imm,
  output logic                        illegal,
  output logic [CNT_WIDTH-1:0]        decode_count
);
  typedef logic [INSTR_TYPE_WIDTH-1:0] type_t;
  // Base codes; contiguous groups are offset by a funct3-derived index.
  localparam type_t T_LUI = 0, T_AUIPC = 1, T_JAL = 2, T_JALR = 3, T_BEQ = 4, T_LB = 10, T_SB = 15;
  localparam type_t T_ADDI = 18, T_SLLI = 24, T_SRLI = 25, T_SRAI = 26, T_ADD = 27, T_SUB = 28, T_SRA = 34;
`ifdef DECODE_RV32M_EN
  localparam type_t T_MUL = 37;
`endif
  typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J, F_X} fmt_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [PC_WIDTH-1:0]  pc;
    type_t                itype;
    logic [REG_WIDTH-1:0] rd;
    logic [REG_WIDTH-1:0] rs1;
    logic [REG_WIDTH-1:0] rs2;
    logic                 rde;
    logic                 rs1e;
    logic                 rs2e;
    logic [WIDTH-1:0]     imm;
    logic                 illegal;
  } ent_t;
  localparam ent_t RST = '{itype: '1, default: '0};
  logic [6:0] op, f7;
  logic [2:0] f3;
  type_t f3t, t;
  fmt_t fmt;
  ent_t d, a, b;
  state_t state, nxt;
  logic load_a, load_b, shift, xfer;
  logic [CNT_WIDTH-1:0] cnt;
  assign op = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign f3t = type_t'(f3);
  always_comb begin
    t = '1;
    fmt = F_X;
    case (op)
      7'b0110111: begin t = T_LUI; fmt = F_U; end
      7'b0010111: begin t = T_AUIPC; fmt = F_U; end
      7'b1101111: begin t = T_JAL; fmt = F_J; end
      7'b1100111: if (f3 == 3'd0) begin t = T_JALR; fmt = F_I; end
      7'b1100011: if (f3[2:1] != 2'b01) begin t = f3[2] ? T_BEQ + f3t - 2 : T_BEQ + f3t; fmt = F_B; end
      7'b0000011: if (f3 != 3'd3 && f3[2:1] != 2'b11) begin t = f3[2] ? T_LB + f3t - 1 : T_LB + f3t; fmt = F_I; end
      7'b0100011: if (f3 < 3'd3) begin t = T_SB + f3t; fmt = F_S; end
      7'b0010011:
        if (f3 == 3'd1) begin
          if (f7 == 7'b0) begin t = T_SLLI; fmt = F_I; end
        end else if (f3 == 3'd5) begin
          if (f7 == 7'b0) begin t = T_SRLI; fmt = F_I; end
          else if (f7 == 7'b0100000) begin t = T_SRAI; fmt = F_I; end
        end else begin
          t = f3 == 3'd0 ? T_ADDI : f3[2:1] == 2'b11 ? T_ADDI + f3t - 2 : T_ADDI + f3t - 1;
          fmt = F_I;
        end
      7'b0110011:
        if (f7 == 7'b0) begin
          t = f3 == 3'd0 ? T_ADD : f3[2:1] == 2'b11 ? T_ADD + f3t + 2 : T_ADD + f3t + 1;
          fmt = F_R;
        end else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) begin
          t = f3 == 3'd0 ? T_SUB : T_SRA;
          fmt = F_R;
        end
`ifdef DECODE_RV32M_EN
        else if (f7 == 7'b0000001) begin
          t = T_MUL + f3t;
          fmt = F_R;
        end
`endif
      default: ;
    endcase
  end
  always_comb begin
    d.pc = in_pc;
    d.itype = t;
    d.rd = REG_WIDTH'(inst[11:7]);
    d.rs1 = REG_WIDTH'(inst[19:15]);
    d.rs2 = REG_WIDTH'(inst[24:20]);
    d.rde = fmt inside {F_R, F_I, F_U, F_J};
    d.rs1e = fmt inside {F_R, F_I, F_S, F_B};
    d.rs2e = fmt inside {F_R, F_S, F_B};
    d.imm = fmt == F_I ? {{(WIDTH-11){inst[31]}}, inst[30:20]} :
            fmt == F_S ? {{(WIDTH-11){inst[31]}}, inst[30:25], inst[11:7]} :
            fmt == F_B ? {{(WIDTH-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0} :
            fmt == F_U ? WIDTH'({inst[31:12], 12'b0}) :
            fmt == F_J ? {{(WIDTH-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0} : '0;
    d.illegal = fmt == F_X;
  end
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign xfer = out_valid && out_ready;
  always_comb begin
    nxt = state;
    load_a = 1'b0;
    load_b = 1'b0;
    shift = 1'b0;
    if (flush) nxt = EMPTY;
    else case (state)
      EMPTY: if (in_valid) begin nxt = ONE; load_a = 1'b1; end
      ONE:
        if (in_valid && out_ready) load_a = 1'b1;
        else if (in_valid) begin nxt = FULL; load_b = 1'b1; end
        else if (out_ready) nxt = EMPTY;
      FULL: if (out_ready) begin nxt = ONE; shift = 1'b1; end
      default: nxt = EMPTY;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= EMPTY;
      a <= RST;
      b <= RST;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt + CNT_WIDTH'(xfer);
      if (load_a) a <= d;
      else if (shift) a <= b;
      if (load_b) b <= d;
    end
  assign {out_pc, instr_type, rd, rs1, rs2, rde, rs1e, rs2e, imm, illegal} = a;
  assign decode_count = cnt;
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked RV32I decode stage with a two-entry skid buffer. It takes fetched instructions (with PC) over a valid/ready interface and emits the decoded fields: type, register indices, valid enables, immediate and illegal flag. The output is a registered valid/ready interface to the register-read stage. It sits between fetch and register read and replaces the purely combinational decode path, so the pipeline can stall, flush and detect illegal encodings.

## Interface
- WIDTH, 32, instruction and immediate width
- PC_WIDTH, 32, program counter width
- REG_WIDTH, 5, register index width
- INSTR_TYPE_WIDTH, 8, width of the shared instruction-type code
- CNT_WIDTH, 16, width of the retired-decode counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- flush  input  1  synchronous kill of all held and in-flight entries
- in_valid  input  1  fetch presents inst/in_pc
- in_ready  output  1  stage can accept this cycle
- inst  input  WIDTH  raw instruction
- in_pc  input  PC_WIDTH  instruction address
- out_valid  output  1  decoded entry available
- out_ready  input  1  downstream accepts
- out_pc  output  PC_WIDTH  PC of the presented entry
- instr_type  output  INSTR_TYPE_WIDTH  shared type code; all ones if unrecognised
- rd, rs1, rs2  output  REG_WIDTH each  inst[11:7], [19:15], [24:20]
- rde, rs1e, rs2e  output  1 each  field-valid enables per format (R/I/S/B/U/J)
- imm  output  WIDTH  sign-extended immediate per format; 0 for R/unknown
- illegal  output  1  opcode/funct3/funct7 combination not recognised
- decode_count  output  CNT_WIDTH  number of entries accepted downstream

## Operation
- Decode logic is combinational on `inst`. Its results are captured with `in_pc` into the output register (slot A) or the skid register (slot B).
- Accept occurs when in_valid && in_ready. Transfer out occurs when out_valid && out_ready.
- in_ready = !skid_valid, taken from a register and not combinational from out_ready.
- State machine:
  - EMPTY (out_valid=0): on accept, go to ONE with A loaded.
  - ONE: transfer and no accept → EMPTY. Transfer and accept → ONE with A replaced. Accept and no transfer → FULL with B loaded. Otherwise hold.
  - FULL (A and B valid, in_ready=0): on transfer, A←B and go to ONE. Otherwise hold.
- Ordering is strictly FIFO, and slot A always drives the outputs.
- Recognised types: LUI, AUIPC, JAL, JALR (funct3=000), LOAD, STORE, the six branches, the nine OP-IMM types (shifts require funct7 of 0000000 or 0100000 as appropriate), and the ten OP types.
  - Anything else sets illegal=1 and instr_type to all ones.
  - rde, rs1e and rs2e are forced to 0 when illegal.
- Immediate formats:
  - I: {21×inst[31], inst[30:20]}
  - S: {21×inst[31], inst[30:25], inst[11:7]}
  - B: {20×inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {12×inst[31], inst[19:12], inst[20], inst[30:21], 0}
- decode_count increments by 1 on every transfer and wraps modulo 2^CNT_WIDTH. It is not affected by flush.
- flush: next state is EMPTY. Any input presented in the flush cycle is dropped, and any transfer in that cycle still counts.

## Timing
- Latency: 1 cycle from accept to out_valid, with no bubble when out_ready stays high. Throughput is 1 per cycle.
- in_ready falls the cycle after entering FULL and rises the cycle after leaving it.
- Reset values: out_valid=0, in_ready=1, decode_count=0. All data outputs are 0 except instr_type=all ones and illegal=0.
- Reset mid-operation discards both slots immediately (asynchronous).
- Outputs hold stable while out_valid && !out_ready.
- Simultaneous flush and accept: flush wins.

## Configuration
- DECODE_RV32M_EN defined:
  - OP with funct7=0000001 decodes to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (funct3 000–111).
  - These set rde=rs1e=rs2e=1, imm=0, illegal=0.
- DECODE_RV32M_EN undefined: those encodings are illegal (illegal=1, instr_type all ones).

## Test plan
- After reset, drive 0x00500093 (addi x1,x0,5) with out_ready=1 → next cycle out_valid=1, instr_type=IS_ADDI, rd=1, rs1=0, rs1e=1, rs2e=0, rde=1, imm=5, decode_count→1 after the transfer.
- Drive 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, rde=0, rs2e=1, illegal=0.
- Hold out_ready=0 and send 3 back-to-back instructions → the first two are held, in_ready=0 from cycle 3, the third waits. Release out_ready → all three emerge in order on consecutive cycles.
- FULL state plus flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, dropped entries never appear, decode_count unchanged.
- Drive 0xFFFFFFFF → illegal=1, instr_type=0xFF, rde=rs1e=rs2e=0.
- Drive 0x02208033 (mul x0,x1,x2) → with DECODE_RV32M_EN: instr_type=IS_MUL, illegal=0. Without it: illegal=1. Assert reset while FULL → out_valid=0 with no clock edge.
